fbuff_line_reader: RTL and testbench

//  Read-side initiator for the VGA frame buffer single-port RAM: fetches packed
//  60-bit words, unpacks 3-bit RGB pixels, and streams them to the pixel pipeline.

---
 rtl/fbuff_line_reader.sv | 156 +++++++++++++++
 tb/tb_fbuff_line_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fbuff_line_reader.sv
// Frame-buffer read initiator: fetches packed pixel words, unpacks them and streams
// a 2x horizontally and vertically upscaled image to the VGA pixel pipeline.
//
// state | meaning
// IDLE  | after reset, waiting for the first frame_start_i
// RUN   | fetching words and streaming pixels of the current frame
// DONE  | final pixel transferred, waiting for the next frame_start_i
module fbuff_line_reader #(
    parameter int FBUFF_WIDTH = 60,
    parameter int FBUFF_DEPTH = 3840,
    parameter int PX_WIDTH    = 3,
    parameter int SRC_W       = 320,
    parameter int SRC_H       = 240,
    parameter int RD_LATENCY  = 1
) (
    input  logic                             clk_i,
    input  logic                             rstn_i,
    input  logic                             frame_start_i,
    output logic [$clog2(FBUFF_DEPTH-1)-1:0] fb_addr_o,
    output logic                             fb_en_o,
    output logic                             fb_we_o,
    output logic [FBUFF_WIDTH-1:0]           fb_din_o,
    input  logic [FBUFF_WIDTH-1:0]           fb_dout_i,
    output logic [PX_WIDTH-1:0]              px_data_o,
    output logic                             px_valid_o,
    input  logic                             px_ready_i,
    output logic                             line_end_o,
    output logic                             frame_end_o
);
    localparam int AW  = $clog2(FBUFF_DEPTH-1);
    localparam int PPW = FBUFF_WIDTH / PX_WIDTH;
    localparam int WPL = SRC_W / PPW;
    localparam int DW  = 2 * SRC_W;
    localparam int DH  = 2 * SRC_H;
    localparam int PIW = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int FWW = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int FLW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int XW  = $clog2(DW);
    localparam int YW  = $clog2(DH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q;
    logic                    fb_en_q;
    logic [AW-1:0]           fb_addr_q;
    logic [AW-1:0]           lbase_q;
    logic [FLW-1:0]          fline_q;
    logic [FWW-1:0]          fwd_q;
    logic                    rep_q;
    logic                    fetch_done_q;
    logic [RD_LATENCY-1:0]   tag_q;
    logic [FBUFF_WIDTH-1:0]  word0_q;
    logic [FBUFF_WIDTH-1:0]  word1_q;
    logic [1:0]              occ_q;
    logic [PIW-1:0]          pi_q;
    logic                    hrep_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;

    logic       run, xfer, pop, cap, issue, last_x, last_y, fwd_last;
    logic [2:0] pending;

    always_comb begin
        run      = (state_q == RUN);
        px_valid_o = run && (occ_q != 2'd0);
        xfer     = px_valid_o && px_ready_i;
        pop      = xfer && hrep_q && (pi_q == PIW'(PPW-1));
        cap      = tag_q[RD_LATENCY-1];
        last_x   = (x_q == XW'(DW-1));
        last_y   = (y_q == YW'(DH-1));
        fwd_last = (fwd_q == FWW'(WPL-1));
        // words buffered plus reads still in the RAM pipeline; capped at two
        pending  = 3'(occ_q) + 3'(fb_en_q) + 3'($countones(tag_q));
        issue    = run && !fetch_done_q && (pending < 3'd2);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            fb_en_q      <= 1'b0;
            fb_addr_q    <= '0;
            lbase_q      <= '0;
            fline_q      <= '0;
            fwd_q        <= '0;
            rep_q        <= 1'b0;
            fetch_done_q <= 1'b0;
            tag_q        <= '0;
            word0_q      <= '0;
            word1_q      <= '0;
            occ_q        <= '0;
            pi_q         <= '0;
            hrep_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else if (frame_start_i) begin
            // clearing the tags drops whatever reads are still in flight
            state_q      <= RUN;
            fb_en_q      <= 1'b0;
            fb_addr_q    <= '0;
            lbase_q      <= '0;
            fline_q      <= '0;
            fwd_q        <= '0;
            rep_q        <= 1'b0;
            fetch_done_q <= 1'b0;
            tag_q        <= '0;
            occ_q        <= '0;
            pi_q         <= '0;
            hrep_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            fb_en_q <= issue;
            tag_q   <= RD_LATENCY'({tag_q, fb_en_q});
            if (issue) begin
                fb_addr_q <= lbase_q + AW'(fwd_q);
                if (fwd_last) begin
                    fwd_q <= '0;
                    rep_q <= ~rep_q;
                    if (rep_q) begin
                        fline_q <= fline_q + FLW'(1);
                        lbase_q <= lbase_q + AW'(WPL);
                        if (fline_q == FLW'(SRC_H-1)) fetch_done_q <= 1'b1;
                    end
                end else begin
                    fwd_q <= fwd_q + FWW'(1);
                end
            end
            if (pop && occ_q == 2'd2) word0_q <= word1_q;
            if (cap) begin
                if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) word0_q <= fb_dout_i;
                else                                         word1_q <= fb_dout_i;
            end
            occ_q <= occ_q - 2'(pop) + 2'(cap);
            if (xfer) begin
                hrep_q <= ~hrep_q;
                if (hrep_q) pi_q <= (pi_q == PIW'(PPW-1)) ? '0 : pi_q + PIW'(1);
                if (last_x) begin
                    x_q <= '0;
                    y_q <= last_y ? '0 : y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
                if (last_x && last_y) state_q <= DONE;
            end
        end
    end

    assign fb_en_o     = fb_en_q;
    assign fb_addr_o   = fb_addr_q;
    assign fb_we_o     = 1'b0;
    assign fb_din_o    = '0;
    assign px_data_o   = PX_WIDTH'(word0_q >> (int'(pi_q) * PX_WIDTH));
    assign line_end_o  = px_valid_o && last_x;
    assign frame_end_o = px_valid_o && last_x && last_y;

endmodule

// File: tb/tb_fbuff_line_reader.sv
// Bench for fbuff_line_reader: two instances (read latency 1 and 2) on a reduced
// 40x6 source image, compared against a frame-level pixel/address model.
module tb_fbuff_line_reader;
    localparam int FW    = 60;
    localparam int PXW   = 3;
    localparam int SW    = 40;
    localparam int SH    = 6;
    localparam int PPW   = FW / PXW;
    localparam int WPL   = SW / PPW;
    localparam int DEPTH = SH * WPL;
    localparam int AW    = $clog2(DEPTH-1);
    localparam int DW    = 2 * SW;
    localparam int DH    = 2 * SH;
    localparam int NPX   = DW * DH;
    localparam int NRD   = DH * WPL;

    logic clk = 1'b0;
    logic rst_n, frame_start, px_ready;
    logic [AW-1:0] addr0, addr1;
    logic en0, en1, we0, we1, v0, v1, le0, le1, fe0_o, fe1_o;
    logic [FW-1:0] din0, din1, dout0, dout1;
    logic [PXW-1:0] px0, px1;

    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] r0, r1a, r1b;

    int n_checks = 0;
    int n_fails  = 0;
    logic [4:0] q0[$], q1[$];
    int a0[$], a1[$];
    int iss0, iss1, xf0, xf1, fec0, fec1, mo0, mo1;

    always #5 clk = ~clk;

    fbuff_line_reader #(.FBUFF_WIDTH(FW), .FBUFF_DEPTH(DEPTH), .PX_WIDTH(PXW),
                        .SRC_W(SW), .SRC_H(SH), .RD_LATENCY(1)) dut (
        .clk_i(clk), .rstn_i(rst_n), .frame_start_i(frame_start),
        .fb_addr_o(addr0), .fb_en_o(en0), .fb_we_o(we0), .fb_din_o(din0),
        .fb_dout_i(dout0), .px_data_o(px0), .px_valid_o(v0), .px_ready_i(px_ready),
        .line_end_o(le0), .frame_end_o(fe0_o));

    fbuff_line_reader #(.FBUFF_WIDTH(FW), .FBUFF_DEPTH(DEPTH), .PX_WIDTH(PXW),
                        .SRC_W(SW), .SRC_H(SH), .RD_LATENCY(2)) dut_l2 (
        .clk_i(clk), .rstn_i(rst_n), .frame_start_i(frame_start),
        .fb_addr_o(addr1), .fb_en_o(en1), .fb_we_o(we1), .fb_din_o(din1),
        .fb_dout_i(dout1), .px_data_o(px1), .px_valid_o(v1), .px_ready_i(px_ready),
        .line_end_o(le1), .frame_end_o(fe1_o));

    // RAM models with one and two cycles of read latency
    always @(posedge clk) begin
        if (en0) r0 <= mem[addr0];
        if (en1) r1a <= mem[addr1];
        r1b <= r1a;
    end
    assign dout0 = r0;
    assign dout1 = r1b;

    always @(negedge clk) begin
        if (en0) begin a0.push_back(int'(addr0)); iss0++; end
        if (en1) begin a1.push_back(int'(addr1)); iss1++; end
        if (iss0 - xf0 / (2*PPW) > mo0) mo0 = iss0 - xf0 / (2*PPW);
        if (iss1 - xf1 / (2*PPW) > mo1) mo1 = iss1 - xf1 / (2*PPW);
        if (v0 && px_ready) begin q0.push_back({fe0_o, le0, px0}); xf0++; if (fe0_o) fec0++; end
        if (v1 && px_ready) begin q1.push_back({fe1_o, le1, px1}); xf1++; if (fe1_o) fec1++; end
    end

    function automatic logic [4:0] exp_rec(int idx);
        int x, y, sx, w, p;
        logic [FW-1:0] wd;
        x  = idx % DW;
        y  = idx / DW;
        sx = x / 2;
        w  = (y / 2) * WPL + sx / PPW;
        p  = sx % PPW;
        wd = mem[w] >> (p * PXW);
        return {(x == DW-1) && (y == DH-1), x == DW-1, wd[PXW-1:0]};
    endfunction

    function automatic int exp_addr(int i);
        return (i / WPL / 2) * WPL + (i % WPL);
    endfunction

    task automatic clear_rec();
        q0.delete(); q1.delete(); a0.delete(); a1.delete();
        iss0 = 0; iss1 = 0; xf0 = 0; xf1 = 0; fec0 = 0; fec1 = 0; mo0 = 0; mo1 = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        clear_rec();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            if (fec0 > 0 && fec1 > 0) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; px_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({en0, en1, v0, v1, le0, fe0_o} !== 6'b0 || addr0 !== '0 || px0 !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs got en=%b%b v=%b%b le=%b fe=%b addr=%0d px=%0d want all 0",
                     en0, en1, v0, v1, le0, fe0_o, addr0, px0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_checks++;
            if ({en0, en1} !== 2'b00) begin
                n_fails++; $display("FAIL idle_fb_en cycle %0d got %b%b want 00", i, en0, en1);
            end
            n_checks++;
            if ({v0, v1} !== 2'b00) begin
                n_fails++; $display("FAIL idle_px_valid cycle %0d got %b%b want 00", i, v0, v1);
            end
            n_checks++;
            if ({we0, we1} !== 2'b00 || din0 !== '0 || din1 !== '0) begin
                n_fails++; $display("FAIL idle_we_din cycle %0d got we=%b%b din=%h want 0", i, we0, we1, din0);
            end
        end
    endtask

    task automatic test_latency();
        int k_en0, k_en1, k_v0, k_v1;
        k_en0 = -1; k_en1 = -1; k_v0 = -1; k_v1 = -1;
        px_ready = 1'b1;
        @(posedge clk); #1;
        clear_rec();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (en0 && k_en0 < 0) k_en0 = k;
            if (en1 && k_en1 < 0) k_en1 = k;
            if (v0 && k_v0 < 0) k_v0 = k;
            if (v1 && k_v1 < 0) k_v1 = k;
        end
        n_checks++;
        if (k_en0 !== 1 || k_en1 !== 1) begin
            n_fails++; $display("FAIL lat_fb_en got %0d/%0d want 1/1", k_en0, k_en1);
        end
        n_checks++;
        if (k_v0 !== 3) begin n_fails++; $display("FAIL lat_valid_l1 got %0d want 3", k_v0); end
        n_checks++;
        if (k_v1 !== 4) begin n_fails++; $display("FAIL lat_valid_l2 got %0d want 4", k_v1); end
    endtask

    task automatic test_full_frame();
        bit to;
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fails++; $display("FAIL full_timeout got %0d want 0", to); end
        for (int d = 0; d < 2; d++) begin
            int n, na;
            n  = (d == 0) ? q0.size() : q1.size();
            na = (d == 0) ? a0.size() : a1.size();
            n_checks++;
            if (n !== NPX) begin n_fails++; $display("FAIL full_count dut%0d got %0d want %0d", d, n, NPX); end
            n_checks++;
            if (((d == 0) ? fec0 : fec1) !== 1) begin
                n_fails++; $display("FAIL full_frame_end_count dut%0d got %0d want 1", d, (d == 0) ? fec0 : fec1);
            end
            for (int i = 0; i < n && i < NPX; i++) begin
                logic [4:0] g;
                g = (d == 0) ? q0[i] : q1[i];
                n_checks++;
                if (g !== exp_rec(i)) begin
                    n_fails++; $display("FAIL full_px dut%0d idx %0d got %h want %h", d, i, g, exp_rec(i));
                end
            end
            n_checks++;
            if (na !== NRD) begin n_fails++; $display("FAIL full_rd_count dut%0d got %0d want %0d", d, na, NRD); end
            for (int i = 0; i < na && i < NRD; i++) begin
                int ga;
                ga = (d == 0) ? a0[i] : a1[i];
                n_checks++;
                if (ga !== exp_addr(i)) begin
                    n_fails++; $display("FAIL full_addr dut%0d rd %0d got %0d want %0d", d, i, ga, exp_addr(i));
                end
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({v0, v1, en0, en1} !== 4'b0) begin
            n_fails++; $display("FAIL done_idle got v=%b%b en=%b%b want 0", v0, v1, en0, en1);
        end
    endtask

    task automatic test_random_ready();
        bit prev_stall;
        logic [PXW-1:0] prev_px;
        bit finished;
        prev_stall = 1'b0; prev_px = '0; finished = 1'b0;
        pulse_start();
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_checks++;
                if (v0 !== 1'b1 || px0 !== prev_px) begin
                    n_fails++; $display("FAIL stall_hold got v=%b px=%0d want v=1 px=%0d", v0, px0, prev_px);
                end
            end
            prev_stall = v0 && !px_ready;
            prev_px    = px0;
            if (fec0 > 0 && fec1 > 0) begin finished = 1'b1; break; end
            @(posedge clk); #1;
            px_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        px_ready = 1'b1;
        n_checks++;
        if (finished !== 1'b1) begin n_fails++; $display("FAIL rand_timeout got %0d want 1", finished); end
        for (int d = 0; d < 2; d++) begin
            int n;
            n = (d == 0) ? q0.size() : q1.size();
            n_checks++;
            if (n !== NPX) begin n_fails++; $display("FAIL rand_count dut%0d got %0d want %0d", d, n, NPX); end
            for (int i = 0; i < n && i < NPX; i++) begin
                logic [4:0] g;
                g = (d == 0) ? q0[i] : q1[i];
                n_checks++;
                if (g !== exp_rec(i)) begin
                    n_fails++; $display("FAIL rand_px dut%0d idx %0d got %h want %h", d, i, g, exp_rec(i));
                end
            end
        end
        n_checks++;
        if (mo0 > 2 || mo1 > 2) begin
            n_fails++; $display("FAIL rand_max_buffered got %0d/%0d want <=2", mo0, mo1);
        end
    endtask

    task automatic test_restart_mid();
        bit to;
        to = 1'b1;
        px_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (xf0 == 5 * DW + 30) begin to = 1'b0; break; end
        end
        n_checks++;
        if (to !== 1'b0) begin n_fails++; $display("FAIL mid_reach_timeout got %0d want 0", to); end
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        clear_rec();
        @(negedge clk);
        n_checks++;
        if ({v0, v1} !== 2'b00) begin n_fails++; $display("FAIL mid_valid_drop got %b%b want 00", v0, v1); end
        wait_done(to);
        n_checks++;
        if (to !== 1'b0) begin n_fails++; $display("FAIL mid_timeout got %0d want 0", to); end
        for (int d = 0; d < 2; d++) begin
            int n, na;
            n  = (d == 0) ? q0.size() : q1.size();
            na = (d == 0) ? a0.size() : a1.size();
            n_checks++;
            if (n !== NPX) begin n_fails++; $display("FAIL mid_count dut%0d got %0d want %0d", d, n, NPX); end
            for (int i = 0; i < n && i < NPX; i++) begin
                logic [4:0] g;
                g = (d == 0) ? q0[i] : q1[i];
                n_checks++;
                if (g !== exp_rec(i)) begin
                    n_fails++; $display("FAIL mid_px dut%0d idx %0d got %h want %h", d, i, g, exp_rec(i));
                end
            end
            for (int i = 0; i < na && i < NRD; i++) begin
                int ga;
                ga = (d == 0) ? a0[i] : a1[i];
                n_checks++;
                if (ga !== exp_addr(i)) begin
                    n_fails++; $display("FAIL mid_addr dut%0d rd %0d got %0d want %0d", d, i, ga, exp_addr(i));
                end
            end
        end
    endtask

    task automatic test_restart_at_end();
        bit to;
        to = 1'b1;
        px_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (xf0 == NPX - 1) begin to = 1'b0; break; end
        end
        n_checks++;
        if (to !== 1'b0) begin n_fails++; $display("FAIL end_reach_timeout got %0d want 0", to); end
        frame_start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fe0_o !== 1'b1) begin n_fails++; $display("FAIL end_frame_end got %b want 1", fe0_o); end
        @(posedge clk); #1;
        frame_start = 1'b0;
        n_checks++;
        if (fec0 !== 1) begin n_fails++; $display("FAIL end_frame_end_count got %0d want 1", fec0); end
        clear_rec();
        @(negedge clk);
        n_checks++;
        if (v0 !== 1'b0) begin n_fails++; $display("FAIL end_valid_drop got %b want 0", v0); end
        @(negedge clk);
        n_checks++;
        if (en0 !== 1'b1 || addr0 !== '0) begin
            n_fails++; $display("FAIL end_restart_read got en=%b addr=%0d want en=1 addr=0", en0, addr0);
        end
        wait_done(to);
        n_checks++;
        if (to !== 1'b0 || q0.size() !== NPX) begin
            n_fails++; $display("FAIL end_next_frame got to=%0d count=%0d want 0/%0d", to, q0.size(), NPX);
        end
        n_checks++;
        if (q0.size() > 1 && (q0[0] !== exp_rec(0) || q0[1] !== exp_rec(1))) begin
            n_fails++; $display("FAIL end_first_px got %h %h want %h", q0[0], q0[1], exp_rec(0));
        end
    endtask

    initial begin
        logic [63:0] tmp;
        for (int k = 0; k < DEPTH; k++) begin
            tmp = {$urandom, $urandom};
            mem[k] = tmp[FW-1:0];
        end
        clear_rec();
        test_reset();
        test_latency();
        test_full_frame();
        test_random_ready();
        test_restart_mid();
        test_restart_at_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got time limit want finish");
        $fatal(1, "watchdog");
    end
endmodule
